// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Two-entry skid register for the boundary between two CPU pipeline stages,
// for example IF/ID or ID/EX. Data moves across the boundary with a
// valid/ready handshake. The downstream ready signal acts as the write enable.
// The skid entry lets upstream ready be a plain register, so there is no
// combinational path from i_ready to o_ready.
//
// Handshake semantics (both sides):
//   A transfer happens on a posedge where valid and ready are both 1.
//     - Accept = i_valid & o_ready (upstream -> this block)
//     - Take   = o_valid & i_ready (this block -> downstream)
//   Accept and Take are evaluated on the same edge.
//   While o_valid=1 and i_ready=0, o_data and o_valid hold constant.
//   Upstream only needs to hold i_data stable on its Accept cycle.
//   Items leave in strict FIFO order, with no loss and no duplication.
//
// Ports:
//   clk      in   1       clock; all state changes on posedge
//   resetn   in   1       synchronous active-low reset
//   i_data   in   LENGTH  upstream payload
//   i_valid  in   1       upstream payload valid
//   o_ready  out  1       block can accept (registered)
//   o_data   out  LENGTH  downstream payload (main register)
//   o_valid  out  1       o_data valid
//   i_ready  in   1       downstream accepts o_data this cycle
//   i_flush  in   1       discard all held entries
//   o_count  out  2       entries held (0..2); this is the FSM state
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int LENGTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [LENGTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic [1:0]        o_count
);

  // The state encoding equals the number of entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LENGTH-1:0] main_q, main_d;
  logic [LENGTH-1:0] skid_q, skid_d;
  logic              valid_q;
  logic              ready_q;
  logic [1:0]        count_q;

  logic accept;
  logic take;

  // ready_q is 0 in FULL, so no Accept can happen there.
  assign accept = i_valid & ready_q;
  assign take   = valid_q & i_ready;

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = i_data;
          state_d = ST_ONE;
        end
      end

      ST_ONE: begin
        if (accept && take) begin
          // Back-to-back streaming. The old main value leaves and the new
          // item replaces it, which sustains 1 item/cycle.
          main_d = i_data;
        end else if (accept) begin
          // Downstream is stalled. The new item parks in skid.
          skid_d  = i_data;
          state_d = ST_FULL;
        end else if (take) begin
          state_d = ST_EMPTY;
        end
      end

      ST_FULL: begin
        // i_valid is ignored here because o_ready is low.
        if (take) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush drops every entry, including any same-cycle Accept. The data
    // registers keep their old contents, which are don't-care once o_valid
    // falls. A same-cycle Take has already completed from the downstream
    // stage's point of view.
    if (i_flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // State and registered outputs. Reset takes priority over flush and over
  // both handshakes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != ST_EMPTY);
      // o_ready comes only from next state, never from i_ready directly.
      ready_q <= (state_d != ST_FULL);
      count_q <= state_d;
    end
  end

  assign o_data  = main_q;
  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_count = count_q;

endmodule
